axi2ahb_cmd_queue: RTL and testbench



---
 rtl/axi2ahb_pkg.sv | 44 ++++
 rtl/axi2ahb_cmdq_mem.sv | 33 +++
 rtl/axi2ahb_cmd_queue.sv | 180 ++++++++++++++++++
 tb/tb_axi2ahb_cmd_queue.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi2ahb_pkg.sv
// Shared definitions for the AXI-to-AHB bridge command path.
// Holds the packed-entry layout (field offsets and total width), the AXI size
// encodings and the occupancy-counter width function.
// Entry layout, LSB first: id(+last) | size | data | addr | write.
package axi2ahb_pkg;

    localparam int unsigned SIZE_W = 3;

    localparam logic [SIZE_W-1:0] SIZE_8B  = 3'd0;
    localparam logic [SIZE_W-1:0] SIZE_16B = 3'd1;
    localparam logic [SIZE_W-1:0] SIZE_32B = 3'd2;
    localparam logic [SIZE_W-1:0] SIZE_64B = 3'd3;

    localparam int unsigned OFF_ID = 0;

    // Pointer/count width: one extra bit so full and empty are distinguishable.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    // idw is the AXI ID width; the stored ID carries one extra last bit.
    function automatic int unsigned off_size(input int unsigned idw);
        return idw + 1;
    endfunction

    function automatic int unsigned off_data(input int unsigned idw);
        return idw + 1 + SIZE_W;
    endfunction

    function automatic int unsigned off_addr(input int unsigned idw, input int unsigned dw);
        return idw + 1 + SIZE_W + dw;
    endfunction

    function automatic int unsigned off_write(input int unsigned idw, input int unsigned dw,
                                              input int unsigned aw);
        return idw + 1 + SIZE_W + dw + aw;
    endfunction

    function automatic int unsigned entry_width(input int unsigned aw, input int unsigned dw,
                                                input int unsigned idw);
        return 1 + aw + dw + SIZE_W + idw + 1;
    endfunction

endpackage

// File: rtl/axi2ahb_cmdq_mem.sv
// Command queue storage: DEPTH x WIDTH register array.
// Ports: clk, rst_n (async active-low, clears every entry),
//        we_i/waddr_i/wdata_i (write port),
//        raddr_i/rdata_o (combinational read port).
module axi2ahb_cmdq_mem #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 109
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       we_i,
    input  logic [$clog2(DEPTH)-1:0]   waddr_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic [$clog2(DEPTH)-1:0]   raddr_i,
    output logic [WIDTH-1:0]           rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Storage array; reset clears it so the head reads zero after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/axi2ahb_cmd_queue.sv
// AXI-side command queue of the AXI-to-AHB bridge.
// Packs write flag, address, write data, size and ID(+last) into one entry
// held in a single FIFO with first-word-fall-through head.
// Ports:
//   aclk, aresetn          clock, async active-low reset
//   flush                  synchronous clear of pointers/count
//   s_valid/s_ready/s_*    push side
//   m_valid/m_ready/m_*    pop side (head fields are combinational)
//   count, almost_full     occupancy and count >= AFULL_THRESH
//   overflow_err, underflow_err, err_clr  sticky error flags and their clear
//   peak_count             max occupancy since reset/flush, only when
//                          AXI2AHB_CMDQ_WATERMARK_EN is defined
module axi2ahb_cmd_queue
    import axi2ahb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned DATA_WIDTH   = 64,
    parameter int unsigned AXI_ID_WIDTH = 8,
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned AFULL_THRESH = DEPTH - 2
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic                          flush,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic                          s_write,
    input  logic [ADDR_WIDTH-1:0]         s_addr,
    input  logic [DATA_WIDTH-1:0]         s_data,
    input  logic [SIZE_W-1:0]             s_size,
    input  logic [AXI_ID_WIDTH:0]         s_id,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic                          m_write,
    output logic [ADDR_WIDTH-1:0]         m_addr,
    output logic [DATA_WIDTH-1:0]         m_data,
    output logic [SIZE_W-1:0]             m_size,
    output logic [AXI_ID_WIDTH:0]         m_id,
    output logic [cnt_width(DEPTH)-1:0]   count,
    output logic                          almost_full,
    output logic                          overflow_err,
    output logic                          underflow_err,
`ifdef AXI2AHB_CMDQ_WATERMARK_EN
    output logic [cnt_width(DEPTH)-1:0]   peak_count,
`endif
    input  logic                          err_clr
);

    localparam int unsigned AW     = $clog2(DEPTH);
    localparam int unsigned PW     = cnt_width(DEPTH);
    localparam int unsigned IDW    = AXI_ID_WIDTH + 1;
    localparam int unsigned EW     = entry_width(ADDR_WIDTH, DATA_WIDTH, AXI_ID_WIDTH);
    localparam int unsigned O_SIZE = off_size(AXI_ID_WIDTH);
    localparam int unsigned O_DATA = off_data(AXI_ID_WIDTH);
    localparam int unsigned O_ADDR = off_addr(AXI_ID_WIDTH, DATA_WIDTH);
    localparam int unsigned O_WR   = off_write(AXI_ID_WIDTH, DATA_WIDTH, ADDR_WIDTH);

    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [PW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          udf_q, udf_d;
    logic          full_c;
    logic          push_c;
    logic          pop_c;
    logic [EW-1:0] wentry_c;
    logic [EW-1:0] rentry_c;

    // Full when the wrap bits differ and the index bits match.
    assign full_c  = (wptr_q[PW-1] != rptr_q[PW-1]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign s_ready = !full_c && !flush;
    assign m_valid = (count_q != '0);
    assign push_c  = s_valid && s_ready;
    assign pop_c   = m_valid && m_ready;

    assign count       = count_q;
    assign almost_full = (count_q >= PW'(AFULL_THRESH));
    assign overflow_err  = ovf_q;
    assign underflow_err = udf_q;

    // Pack the incoming command into one entry.
    assign wentry_c = {s_write, s_addr, s_data, s_size, s_id};

    axi2ahb_cmdq_mem #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_mem (
        .clk     (aclk),
        .rst_n   (aresetn),
        .we_i    (push_c),
        .waddr_i (wptr_q[AW-1:0]),
        .wdata_i (wentry_c),
        .raddr_i (rptr_q[AW-1:0]),
        .rdata_o (rentry_c)
    );

    // Unpack the head entry.
    assign m_write = rentry_c[O_WR];
    assign m_addr  = rentry_c[O_ADDR +: ADDR_WIDTH];
    assign m_data  = rentry_c[O_DATA +: DATA_WIDTH];
    assign m_size  = rentry_c[O_SIZE +: SIZE_W];
    assign m_id    = rentry_c[OFF_ID +: IDW];

    // Pointer and occupancy next-state; flush discards any concurrent pop.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push_c) begin
                wptr_d = wptr_q + PW'(1);
            end
            if (pop_c) begin
                rptr_d = rptr_q + PW'(1);
            end
            if (push_c && !pop_c) begin
                count_d = count_q + PW'(1);
            end else if (!push_c && pop_c) begin
                count_d = count_q - PW'(1);
            end
        end
    end

    // Sticky errors: a set condition overrides err_clr in the same cycle.
    always_comb begin
        ovf_d = ovf_q && !err_clr;
        udf_d = udf_q && !err_clr;
        if (s_valid && full_c && !flush) begin
            ovf_d = 1'b1;
        end
        if (m_ready && !m_valid) begin
            udf_d = 1'b1;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

`ifdef AXI2AHB_CMDQ_WATERMARK_EN
    logic [PW-1:0] peak_q, peak_d;

    // High-water mark tracks next-count; flush restarts it from zero.
    always_comb begin
        peak_d = peak_q;
        if (flush) begin
            peak_d = '0;
        end else if (count_d > peak_q) begin
            peak_d = count_d;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            peak_q <= '0;
        end else begin
            peak_q <= peak_d;
        end
    end

    assign peak_count = peak_q;
`endif

endmodule

// File: tb/tb_axi2ahb_cmd_queue.sv
// Self-checking bench for axi2ahb_cmd_queue (default parameters, DEPTH=8).
module tb_axi2ahb_cmd_queue;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned CW    = 4;

    typedef struct packed {
        logic        w;
        logic [31:0] a;
        logic [63:0] d;
        logic [2:0]  sz;
        logic [8:0]  id;
    } ent_t;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic          flush = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic          s_write = 1'b0;
    logic [31:0]   s_addr = '0;
    logic [63:0]   s_data = '0;
    logic [2:0]    s_size = '0;
    logic [8:0]    s_id = '0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic          m_write;
    logic [31:0]   m_addr;
    logic [63:0]   m_data;
    logic [2:0]    m_size;
    logic [8:0]    m_id;
    logic [CW-1:0] count;
    logic          almost_full;
    logic          overflow_err;
    logic          underflow_err;
    logic          err_clr = 1'b0;
`ifdef AXI2AHB_CMDQ_WATERMARK_EN
    logic [CW-1:0] peak_count;
`endif

    int   n_tests = 0;
    int   n_fail  = 0;
    ent_t sb[$];
    logic ovf_m = 1'b0;
    logic udf_m = 1'b0;
    int   peak_m = 0;

    always #5 aclk = ~aclk;

    axi2ahb_cmd_queue dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .flush         (flush),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .s_write       (s_write),
        .s_addr        (s_addr),
        .s_data        (s_data),
        .s_size        (s_size),
        .s_id          (s_id),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_write       (m_write),
        .m_addr        (m_addr),
        .m_data        (m_data),
        .m_size        (m_size),
        .m_id          (m_id),
        .count         (count),
        .almost_full   (almost_full),
        .overflow_err  (overflow_err),
        .underflow_err (underflow_err),
`ifdef AXI2AHB_CMDQ_WATERMARK_EN
        .peak_count    (peak_count),
`endif
        .err_clr       (err_clr)
    );

    function automatic ent_t mk(input int unsigned id);
        ent_t e;
        e.w  = id[0];
        e.a  = 32'h1000 + (id << 4);
        e.d  = {$urandom(), $urandom()};
        e.sz = 3'(id % 4);
        e.id = 9'(id);
        return e;
    endfunction

    task automatic drive(input ent_t e);
        s_write = e.w;
        s_addr  = e.a;
        s_data  = e.d;
        s_size  = e.sz;
        s_id    = e.id;
    endtask

    task automatic model_reset();
        sb.delete();
        ovf_m  = 1'b0;
        udf_m  = 1'b0;
        peak_m = 0;
    endtask

    // One clock: check state at the falling edge against the model, score any
    // pop, then advance the model across the rising edge.
    task automatic step();
        logic exp_ready, exp_mvalid, full_m, do_push, do_pop;
        ent_t h, cur, head;
        @(negedge aclk);
        full_m     = (sb.size() == DEPTH);
        exp_ready  = !full_m && !flush;
        exp_mvalid = (sb.size() != 0);
        n_tests++;
        if (s_ready !== exp_ready) begin
            n_fail++; $display("FAIL s_ready: got %0b expected %0b", s_ready, exp_ready);
        end
        n_tests++;
        if (m_valid !== exp_mvalid) begin
            n_fail++; $display("FAIL m_valid: got %0b expected %0b", m_valid, exp_mvalid);
        end
        n_tests++;
        if (count !== CW'(sb.size())) begin
            n_fail++; $display("FAIL count: got %0d expected %0d", count, sb.size());
        end
        n_tests++;
        if (almost_full !== (sb.size() >= DEPTH - 2)) begin
            n_fail++; $display("FAIL almost_full: got %0b at model count %0d", almost_full, sb.size());
        end
        n_tests++;
        if (overflow_err !== ovf_m || underflow_err !== udf_m) begin
            n_fail++;
            $display("FAIL err_flags: got ovf=%0b udf=%0b expected ovf=%0b udf=%0b",
                     overflow_err, underflow_err, ovf_m, udf_m);
        end
`ifdef AXI2AHB_CMDQ_WATERMARK_EN
        n_tests++;
        if (peak_count !== CW'(peak_m)) begin
            n_fail++; $display("FAIL peak_count: got %0d expected %0d", peak_count, peak_m);
        end
`endif
        do_pop  = m_ready && exp_mvalid;
        do_push = s_valid && exp_ready;
        cur     = '{s_write, s_addr, s_data, s_size, s_id};
        if (do_pop) begin
            h    = sb.pop_front();
            head = '{m_write, m_addr, m_data, m_size, m_id};
            n_tests++;
            if (head !== h) begin
                n_fail++; $display("FAIL pop_entry: got %h expected %h", head, h);
            end
        end
        if (flush) sb.delete();
        else if (do_push) sb.push_back(cur);
        ovf_m = (ovf_m && !err_clr) || (s_valid && full_m && !flush);
        udf_m = (udf_m && !err_clr) || (m_ready && !exp_mvalid);
        if (flush) peak_m = 0;
        else if (sb.size() > peak_m) peak_m = sb.size();
        if (!aresetn) model_reset();
        @(posedge aclk);
        #1;
    endtask

    task automatic push_n(input int n, input int base);
        s_valid = 1'b1;
        for (int i = 0; i < n; i++) begin
            drive(mk(base + i));
            step();
        end
        s_valid = 1'b0;
    endtask

    task automatic test_reset();
        model_reset();
        step();
        n_tests++;
        if (m_addr !== '0 || m_data !== '0 || m_id !== '0 || m_write !== 1'b0 || m_size !== '0) begin
            n_fail++; $display("FAIL reset_head: got addr=%h data=%h id=%h", m_addr, m_data, m_id);
        end
        aresetn = 1'b1;
        step();
    endtask

    task automatic test_single_push();
        ent_t e;
        e = '{1'b1, 32'h1000, 64'hDEADBEEF_00000001, 3'd3, 9'h005};
        drive(e);
        s_valid = 1'b1;
        step();
        s_valid = 1'b0;
        n_tests++;
        if (m_valid !== 1'b1 || count !== CW'(1)) begin
            n_fail++; $display("FAIL single_push: got m_valid=%0b count=%0d expected 1/1", m_valid, count);
        end
        n_tests++;
        if ({m_write, m_addr, m_data, m_size, m_id} !== e) begin
            n_fail++; $display("FAIL single_fields: got %h expected %h",
                               {m_write, m_addr, m_data, m_size, m_id}, e);
        end
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        step();
    endtask

    task automatic test_fill_overflow();
        s_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            drive(mk(i));
            step();
            n_tests++;
            if (count !== CW'(i + 1) || almost_full !== (i + 1 >= 6)) begin
                n_fail++; $display("FAIL fill: got count=%0d af=%0b at push %0d", count, almost_full, i);
            end
        end
        n_tests++;
        if (s_ready !== 1'b0) begin
            n_fail++; $display("FAIL full_ready: got %0b expected 0", s_ready);
        end
        drive(mk(99));
        step();
        n_tests++;
        if (overflow_err !== 1'b1) begin
            n_fail++; $display("FAIL overflow_set: got %0b expected 1", overflow_err);
        end
        err_clr = 1'b1;
        step();
        n_tests++;
        if (overflow_err !== 1'b1) begin
            n_fail++; $display("FAIL overflow_set_wins: got %0b expected 1", overflow_err);
        end
        s_valid = 1'b0;
        step();
        err_clr = 1'b0;
        n_tests++;
        if (overflow_err !== 1'b0) begin
            n_fail++; $display("FAIL overflow_clr: got %0b expected 0", overflow_err);
        end
    endtask

    task automatic test_full_push_pop();
        int k;
        s_valid = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            drive(mk(20 + i));
            step();
        end
        s_valid = 1'b0;
        for (int i = 0; i < 2 * DEPTH && sb.size() != 0; i++) step();
        m_ready = 1'b0;
        push_n(DEPTH, 0);
        m_ready = 1'b1;
        k = 0;
        for (int i = 0; i < 2 * DEPTH && sb.size() != 0; i++) begin
            n_tests++;
            if (m_id !== 9'(k)) begin
                n_fail++; $display("FAIL wrap_order: got id %0d expected %0d", m_id, k);
            end
            k++;
            step();
        end
        m_ready = 1'b0;
        n_tests++;
        if (k != DEPTH || m_valid !== 1'b0) begin
            n_fail++; $display("FAIL wrap_drain: got %0d pops m_valid=%0b expected %0d/0", k, m_valid, DEPTH);
        end
    endtask

    task automatic test_back_to_back();
        push_n(4, 100);
        s_valid = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            drive(mk(200 + i));
            step();
            n_tests++;
            if (count !== CW'(4)) begin
                n_fail++; $display("FAIL steady_count: got %0d expected 4", count);
            end
        end
        s_valid = 1'b0;
        for (int i = 0; i < DEPTH && sb.size() != 0; i++) step();
        m_ready = 1'b0;
    endtask

    task automatic test_flush();
        push_n(5, 300);
        flush   = 1'b1;
        s_valid = 1'b1;
        m_ready = 1'b1;
        drive(mk(399));
        step();
        flush   = 1'b0;
        s_valid = 1'b0;
        m_ready = 1'b0;
        n_tests++;
        if (count !== '0 || m_valid !== 1'b0) begin
            n_fail++; $display("FAIL flush: got count=%0d m_valid=%0b expected 0/0", count, m_valid);
        end
`ifdef AXI2AHB_CMDQ_WATERMARK_EN
        n_tests++;
        if (peak_count !== '0) begin
            n_fail++; $display("FAIL flush_peak: got %0d expected 0", peak_count);
        end
`endif
        step();
    endtask

    task automatic test_reset_mid();
        push_n(3, 400);
        s_valid = 1'b1;
        drive(mk(403));
        #1;
        aresetn = 1'b0;
        #1;
        n_tests++;
        if (count !== '0 || m_valid !== 1'b0 || s_ready !== 1'b1 || almost_full !== 1'b0
            || m_data !== '0 || m_addr !== '0 || m_id !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got count=%0d m_valid=%0b s_ready=%0b data=%h",
                     count, m_valid, s_ready, m_data);
        end
        model_reset();
        s_valid = 1'b0;
        step();
        aresetn = 1'b1;
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        n_tests++;
        if (underflow_err !== 1'b1) begin
            n_fail++; $display("FAIL underflow_set: got %0b expected 1", underflow_err);
        end
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_single_push();
        test_fill_overflow();
        test_full_push_pop();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
